// File: rtl/alu_ctrl_muldiv_seq.sv
// ALU control decoder plus an iterative signed MULT/DIV sequencer that owns HI/LO.
// The decoder is purely combinational; the sequencer stalls upstream while it iterates.
module alu_ctrl_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int FUNCW = 6,
    parameter int UOPW  = 4,
    parameter int AOPW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [UOPW-1:0]  UC_aluOp,
    input  logic [FUNCW-1:0] func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [AOPW-1:0]  ALU_aluOp,
    output logic             illegal,
    output logic             stall,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 mul_q, mul_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 md_done_q, md_done_d;
    logic                 dz_pulse_q, dz_pulse_d;

    logic                 is_legal, is_mult, is_div;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ALU_aluOp = AOPW'(4'b0110);
        is_legal  = 1'b1;
        is_mult   = 1'b0;
        is_div    = 1'b0;
        case (UC_aluOp)
            UOPW'(4'b0001), UOPW'(4'b0100), UOPW'(4'b1000): ALU_aluOp = AOPW'(4'b0010);
            UOPW'(4'b0000): ALU_aluOp = AOPW'(4'b0000);
            UOPW'(4'b0010): ALU_aluOp = AOPW'(4'b0001);
            UOPW'(4'b0011): ALU_aluOp = AOPW'(4'b0100);
            UOPW'(4'b0101): ALU_aluOp = AOPW'(4'b0011);
            UOPW'(4'b0111): begin
                case (func)
                    FUNCW'(6'b100100): ALU_aluOp = AOPW'(4'b0000);
                    FUNCW'(6'b100101): ALU_aluOp = AOPW'(4'b0001);
                    FUNCW'(6'b100000): ALU_aluOp = AOPW'(4'b0010);
                    FUNCW'(6'b100010): ALU_aluOp = AOPW'(4'b0011);
                    FUNCW'(6'b101010): ALU_aluOp = AOPW'(4'b0100);
                    FUNCW'(6'b011010): begin ALU_aluOp = AOPW'(4'b0101); is_div = 1'b1; end
                    FUNCW'(6'b000000): ALU_aluOp = AOPW'(4'b0110);
                    FUNCW'(6'b011000): begin ALU_aluOp = AOPW'(4'b0111); is_mult = 1'b1; end
                    FUNCW'(6'b100110): ALU_aluOp = AOPW'(4'b1111);
                    default:           is_legal = 1'b0;
                endcase
            end
            default: is_legal = 1'b0;
        endcase
        illegal = valid_in & ~is_legal;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        mul_d      = mul_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        md_done_d  = 1'b0;
        dz_pulse_d = 1'b0;

        a_abs    = op_a[WIDTH-1] ? -op_a : op_a;
        b_abs    = op_b[WIDTH-1] ? -op_b : op_b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (valid_in && (is_mult || is_div)) begin
                    cnt_d  = CNTW'(WIDTH-1);
                    mul_d  = is_mult;
                    dz_d   = 1'b0;
                    neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    rneg_d = op_a[WIDTH-1];
                    if (is_mult) begin
                        m_d     = a_abs;
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        state_d = S_MUL;
                    end else if (op_b == '0) begin
                        // Divide-by-zero result is staged raw so DONE passes it straight through.
                        acc_d   = {op_a, {WIDTH{1'b1}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        m_d     = b_abs;
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DIV: begin
                // Restoring step: keep the trial difference only when it did not borrow.
                acc_d = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (mul_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                md_done_d  = 1'b1;
                dz_pulse_d = dz_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            mul_q      <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            md_done_q  <= 1'b0;
            dz_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            mul_q      <= mul_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            md_done_q  <= md_done_d;
            dz_pulse_q <= dz_pulse_d;
        end
    end

    assign stall       = (state_q != S_IDLE);
    assign md_done     = md_done_q;
    assign div_by_zero = dz_pulse_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv_seq.sv
// Directed bench: table-driven decode sweep plus hand-written MULT/DIV sequences on 32- and 8-bit instances.
module tb_alu_ctrl_muldiv_seq;

    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, valid8;
    logic [3:0]  uc;
    logic [5:0]  fn;
    logic [31:0] opa, opb;
    logic [7:0]  a8, b8;

    logic [3:0]  aop, aop8;
    logic        ill, ill8, stl, stl8, md, md8, dz, dz8;
    logic [31:0] hi, lo;
    logic [7:0]  hi8, lo8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid), .UC_aluOp(uc), .func(fn),
        .op_a(opa), .op_b(opb), .ALU_aluOp(aop), .illegal(ill), .stall(stl),
        .md_done(md), .div_by_zero(dz), .hi(hi), .lo(lo)
    );

    alu_ctrl_muldiv_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid8), .UC_aluOp(uc), .func(fn),
        .op_a(a8), .op_b(b8), .ALU_aluOp(aop8), .illegal(ill8), .stall(stl8),
        .md_done(md8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic       v;
        logic [3:0] uc;
        logic [5:0] fn;
        logic [3:0] aop;
        logic       ill;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one MULT/DIV on the chosen instance and follow it to md_done.
    task automatic run_md(input string name, input bit w8, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat, input bit disturb);
        int  k;
        bit  seen;
        bit  stall_ok;
        @(negedge clk);
        uc = 4'b0111;
        fn = f;
        if (w8) begin valid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin valid  = 1'b1; opa = a;     opb = b;     end
        @(posedge clk);
        @(negedge clk);
        k = 0; seen = 1'b0; stall_ok = 1'b1;
        while (k < 200 && !seen) begin
            if (w8 ? md8 : md) begin
                seen = 1'b1;
            end else begin
                if (!(w8 ? stl8 : stl)) stall_ok = 1'b0;
                if (disturb) begin
                    fn = F_DIV;
                    if (w8) begin valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); end
                    else    begin valid  = 1'b1; opa = $urandom;    opb = $urandom;    end
                end else begin
                    valid = 1'b0; valid8 = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        valid = 1'b0; valid8 = 1'b0;
        check({name, " done seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(k), 32'(elat));
        check({name, " stall while busy"}, 32'(stall_ok), 32'd1);
        check({name, " stall at done"}, 32'(w8 ? stl8 : stl), 32'd0);
        check({name, " hi"}, w8 ? {24'd0, hi8} : hi, ehi);
        check({name, " lo"}, w8 ? {24'd0, lo8} : lo, elo);
        check({name, " div_by_zero"}, 32'(w8 ? dz8 : dz), 32'(edz));
        @(negedge clk);
        check({name, " md_done pulse ends"}, 32'(w8 ? md8 : md), 32'd0);
    endtask

    initial begin
        int md_seen;
        rst = 1'b1; valid = 1'b0; valid8 = 1'b0;
        uc = 4'b0000; fn = 6'b000000;
        opa = '0; opb = '0; a8 = '0; b8 = '0;

        vt.push_back('{1'b1, 4'b0001, 6'b000000, 4'b0010, 1'b0});
        vt.push_back('{1'b1, 4'b0000, 6'b000000, 4'b0000, 1'b0});
        vt.push_back('{1'b1, 4'b0010, 6'b111111, 4'b0001, 1'b0});
        vt.push_back('{1'b1, 4'b0011, 6'b000000, 4'b0100, 1'b0});
        vt.push_back('{1'b1, 4'b0101, 6'b000000, 4'b0011, 1'b0});
        vt.push_back('{1'b1, 4'b0100, 6'b000000, 4'b0010, 1'b0});
        vt.push_back('{1'b1, 4'b1000, 6'b000000, 4'b0010, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b100100, 4'b0000, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b100101, 4'b0001, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b100000, 4'b0010, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b100010, 4'b0011, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b101010, 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'b0111, 6'b011010, 4'b0101, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b000000, 4'b0110, 1'b0});
        vt.push_back('{1'b0, 4'b0111, 6'b011000, 4'b0111, 1'b0});
        vt.push_back('{1'b1, 4'b0111, 6'b100110, 4'b1111, 1'b0});
        vt.push_back('{1'b1, 4'b1111, 6'b100000, 4'b0110, 1'b1});
        vt.push_back('{1'b1, 4'b0110, 6'b000000, 4'b0110, 1'b1});
        vt.push_back('{1'b1, 4'b0111, 6'b000001, 4'b0110, 1'b1});
        vt.push_back('{1'b0, 4'b1111, 6'b000000, 4'b0110, 1'b0});

        repeat (2) @(negedge clk);
        check("reset stall", 32'(stl), 32'd0);
        check("reset md_done", 32'(md), 32'd0);
        check("reset div_by_zero", 32'(dz), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            valid = vt[i].v; uc = vt[i].uc; fn = vt[i].fn;
            #1;
            check($sformatf("decode[%0d] aluop", i), 32'(aop), 32'(vt[i].aop));
            check($sformatf("decode[%0d] illegal", i), 32'(ill), 32'(vt[i].ill));
        end
        @(negedge clk);
        valid = 1'b0;
        check("decode sweep leaves fsm idle", 32'(stl), 32'd0);

        run_md("mult 7*-3",       1'b0, F_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
        run_md("div -7/2",        1'b0, F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        run_md("div min/-1",      1'b0, F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
        run_md("div 5/0",         1'b0, F_DIV,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
        run_md("mult min*min",    1'b0, F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 1'b0);
        run_md("mult -2^16*2^16", 1'b0, F_MULT, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 1'b0);
        run_md("div 100/-7 busy", 1'b0, F_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 33, 1'b1);

        @(negedge clk);
        uc = 4'b0111; fn = F_MULT; valid = 1'b1; opa = 32'd9; opb = 32'd9;
        @(posedge clk);
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midop reset stall", 32'(stl), 32'd0);
        check("midop reset md_done", 32'(md), 32'd0);
        check("midop reset hi", hi, 32'd0);
        check("midop reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        md_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md) md_seen++;
        end
        check("no md_done after reset", 32'(md_seen), 32'd0);
        check("lo held at zero after reset", lo, 32'd0);
        run_md("mult after reset", 1'b0, F_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33, 1'b0);

        run_md("w8 mult 7*-3",    1'b1, F_MULT, 32'h07, 32'hFD, 32'hFF, 32'hEB, 1'b0, 9, 1'b0);
        run_md("w8 div -7/2",     1'b1, F_DIV,  32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 9, 1'b0);
        run_md("w8 div min/-1",   1'b1, F_DIV,  32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 9, 1'b1);
        run_md("w8 div 5/0",      1'b1, F_DIV,  32'h05, 32'h00, 32'h05, 32'hFF, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
